// File: rtl/chien_par.sv
// Parallel Chien search over GF(2^6), GF(2^8) or GF(2^10), chosen at run time.
// Evaluates the error locator at P codeword positions per cycle and reports the roots.
//
// state | meaning
// IDLE  | waiting for start; the done cycle is also spent here with busy still high
// EVAL  | one block of P positions evaluated per cycle
// FIN   | pulse done and resolve fail
module chien_par #(
    parameter int N_MAX = 1023,
    parameter int T_MAX = 4,
    parameter int M_MAX = 10,
    parameter int P     = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic [9:0]                 n,
    input  logic [3:0]                 m,
    input  logic [3:0]                 degree,
    input  logic [(T_MAX+1)*M_MAX-1:0] sigma,
    output logic                       busy,
    output logic                       done,
    output logic [N_MAX-1:0]           err_vec,
    output logic [9:0]                 err_cnt,
    output logic                       fail
);

    localparam int IW = $clog2(N_MAX);

    typedef enum logic [1:0] {IDLE, EVAL, FIN} state_t;

    state_t           state;
    logic [9:0]       n_q;
    logic [3:0]       degree_q;
    logic [M_MAX:0]   poly_q;
    logic             bad_q;
    logic [10:0]      base;
    logic [M_MAX-1:0] g   [0:T_MAX];
    logic [M_MAX-1:0] cur [0:T_MAX];
    logic [M_MAX-1:0] acc;
    logic [P-1:0]     hit;
    logic [P-1:0]     valid;
    logic [10:0]      hit_cnt;
    logic [10:0]      cnt_sum;
    logic [9:0]       cnt_next;
    logic [M_MAX:0]   poly_sel;
    logic [M_MAX-1:0] fmask;
    logic             m_ok;
    logic             skip;

    // Multiply by alpha^-1: shift right, folding the polynomial in when bit 0 is set.
    function automatic logic [M_MAX-1:0] div_alpha(input logic [M_MAX-1:0] x,
                                                   input logic [M_MAX:0]   poly);
        logic [M_MAX:0] t;
        t = {1'b0, x} ^ (x[0] ? poly : '0);
        return M_MAX'(t >> 1);
    endfunction

    always_comb begin
        poly_sel = '0;
        m_ok     = 1'b0;
        case (m)
            4'd6:  begin poly_sel = (M_MAX+1)'(11'h043); m_ok = (M_MAX >= 6);  end
            4'd8:  begin poly_sel = (M_MAX+1)'(11'h11d); m_ok = (M_MAX >= 8);  end
            4'd10: begin poly_sel = (M_MAX+1)'(11'h409); m_ok = (M_MAX >= 10); end
            default: begin poly_sel = '0; m_ok = 1'b0; end
        endcase
        fmask = ~({M_MAX{1'b1}} << m);
        skip  = !m_ok || (degree > 4'(T_MAX)) || (n == 10'd0);
    end

    // cur[j] walks sigma_j * alpha^(-j*i) across the block; its final value seeds the next block.
    always_comb begin
        hit     = '0;
        valid   = '0;
        hit_cnt = '0;
        acc     = '0;
        for (int j = 0; j <= T_MAX; j++) cur[j] = g[j];
        for (int p = 0; p < P; p++) begin
            acc = '0;
            for (int j = 0; j <= T_MAX; j++) acc = acc ^ cur[j];
            hit[p]   = (acc == '0);
            valid[p] = ((base + 11'(p)) < {1'b0, n_q});
            if (hit[p] && valid[p]) hit_cnt = hit_cnt + 11'd1;
            for (int j = 1; j <= T_MAX; j++)
                for (int s = 0; s < j; s++)
                    cur[j] = div_alpha(cur[j], poly_q);
        end
        cnt_sum  = {1'b0, err_cnt} + hit_cnt;
        cnt_next = (cnt_sum > 11'd1023) ? 10'd1023 : cnt_sum[9:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_vec  <= '0;
            err_cnt  <= '0;
            fail     <= 1'b0;
            n_q      <= '0;
            degree_q <= '0;
            poly_q   <= '0;
            bad_q    <= 1'b0;
            base     <= '0;
            for (int j = 0; j <= T_MAX; j++) g[j] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start && !busy) begin
                        busy     <= 1'b1;
                        err_vec  <= '0;
                        err_cnt  <= '0;
                        fail     <= 1'b0;
                        n_q      <= n;
                        degree_q <= degree;
                        poly_q   <= poly_sel;
                        base     <= '0;
                        bad_q    <= !m_ok || (degree > 4'(T_MAX));
                        for (int j = 0; j <= T_MAX; j++)
                            g[j] <= (degree >= 4'(j)) ? (sigma[j*M_MAX +: M_MAX] & fmask) : '0;
                        state <= skip ? FIN : EVAL;
                    end
                end
                EVAL: begin
                    for (int j = 0; j <= T_MAX; j++) g[j] <= cur[j];
                    for (int p = 0; p < P; p++)
                        if (valid[p]) err_vec[IW'(base + 11'(p))] <= hit[p];
                    err_cnt <= cnt_next;
                    base    <= base + 11'(P);
                    if ((base + 11'(P)) >= {1'b0, n_q}) state <= FIN;
                end
                FIN: begin
                    done  <= 1'b1;
                    fail  <= bad_q || ({6'b0, degree_q} != err_cnt);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chien_par.sv
// Scoreboard bench for chien_par: a log/antilog GF model predicts roots, counts,
// fail and latency for P=8, with P=1 and P=32 instances for the block-width sweep.
module tb_chien_par;

    localparam int N_MAX = 1023;
    localparam int T_MAX = 4;
    localparam int M_MAX = 10;
    localparam int SW    = (T_MAX+1)*M_MAX;

    typedef struct {
        logic [N_MAX-1:0] vec;
        int               cnt;
        int               fail;
        int               lat;
        int               scyc;
    } exp_t;

    logic clk = 1'b0, rstn = 1'b0, start = 1'b0, start_aux = 1'b0;
    logic [9:0] n = '0;
    logic [3:0] m = '0, degree = '0;
    logic [SW-1:0] sigma = '0;

    logic busy8, done8, fail8, busy1, done1, fail1, busy32, done32, fail32;
    logic [N_MAX-1:0] vec8, vec1, vec32;
    logic [9:0] cnt8, cnt1, cnt32;

    exp_t sb8[$], sb1[$], sb32[$];
    exp_t last8, e1, e32;
    int checks = 0, errors = 0, cyc = 0, cur_q = 63;
    int exp_tab [0:1023];
    int log_tab [0:1023];

    chien_par #(.N_MAX(N_MAX), .T_MAX(T_MAX), .M_MAX(M_MAX), .P(8)) dut8 (
        .clk(clk), .rstn(rstn), .start(start), .n(n), .m(m), .degree(degree), .sigma(sigma),
        .busy(busy8), .done(done8), .err_vec(vec8), .err_cnt(cnt8), .fail(fail8));
    chien_par #(.N_MAX(N_MAX), .T_MAX(T_MAX), .M_MAX(M_MAX), .P(1)) dut1 (
        .clk(clk), .rstn(rstn), .start(start_aux), .n(n), .m(m), .degree(degree), .sigma(sigma),
        .busy(busy1), .done(done1), .err_vec(vec1), .err_cnt(cnt1), .fail(fail1));
    chien_par #(.N_MAX(N_MAX), .T_MAX(T_MAX), .M_MAX(M_MAX), .P(32)) dut32 (
        .clk(clk), .rstn(rstn), .start(start_aux), .n(n), .m(m), .degree(degree), .sigma(sigma),
        .busy(busy32), .done(done32), .err_vec(vec32), .err_cnt(cnt32), .fail(fail32));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int first_diff(input logic [N_MAX-1:0] a, input logic [N_MAX-1:0] b);
        for (int i = 0; i < N_MAX; i++) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    task automatic build(input int mm);
        int poly, x;
        poly  = (mm == 6) ? 'h43 : (mm == 8) ? 'h11d : 'h409;
        cur_q = (1 << mm) - 1;
        x = 1;
        for (int e = 0; e < cur_q; e++) begin
            exp_tab[e] = x;
            log_tab[x] = e;
            x = x << 1;
            if ((x & (1 << mm)) != 0) x = x ^ poly;
        end
    endtask

    function automatic int ap(input int e);
        return exp_tab[e % cur_q];
    endfunction

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_tab[(log_tab[a] + log_tab[b]) % cur_q];
    endfunction

    function automatic logic [SW-1:0] pack(input int c0, input int c1, input int c2,
                                           input int c3, input int c4);
        return {M_MAX'(c4), M_MAX'(c3), M_MAX'(c2), M_MAX'(c1), M_MAX'(c0)};
    endfunction

    task automatic model(input int nn, input int mm, input int dd, input logic [SW-1:0] sg,
                         input int pp, output exp_t e);
        int s, c;
        e.vec  = '0;
        e.cnt  = 0;
        e.scyc = cyc;
        e.lat  = 1;
        if (dd > T_MAX || !(mm == 6 || mm == 8 || mm == 10)) begin
            e.fail = 1;
            return;
        end
        if (nn == 0) begin
            e.fail = (dd != 0) ? 1 : 0;
            return;
        end
        build(mm);
        for (int i = 0; i < nn; i++) begin
            s = 0;
            for (int j = 0; j <= dd; j++) begin
                c = int'(sg[j*M_MAX +: M_MAX]) & cur_q;
                if (c != 0) s = s ^ exp_tab[(log_tab[c] + cur_q - (i*j) % cur_q) % cur_q];
            end
            if (s == 0) begin
                e.vec[i] = 1'b1;
                e.cnt++;
            end
        end
        if (e.cnt > 1023) e.cnt = 1023;
        e.fail = (e.cnt != dd) ? 1 : 0;
        e.lat  = (nn + pp - 1) / pp + 1;
    endtask

    task automatic score(input string tag, input exp_t e, input logic [N_MAX-1:0] vec,
                         input logic [9:0] cnt, input logic f);
        check({tag, " latency"}, cyc - e.scyc, e.lat);
        check({tag, " err_vec first diff"}, first_diff(vec, e.vec), -1);
        check({tag, " err_cnt"}, cnt, e.cnt);
        check({tag, " fail"}, f, e.fail);
    endtask

    // Caller is aligned to a falling edge; the next rising edge accepts start.
    task automatic drive(input int nn, input int mm, input int dd, input logic [SW-1:0] sg,
                         input bit aux);
        exp_t e;
        n = 10'(nn); m = 4'(mm); degree = 4'(dd); sigma = sg;
        if (aux) start_aux = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start_aux = 1'b0;
        if (aux) begin
            model(nn, mm, dd, sg, 1, e);  sb1.push_back(e);
            model(nn, mm, dd, sg, 32, e); sb32.push_back(e);
        end else begin
            check("busy after start", busy8, 1);
            check("err_cnt cleared", cnt8, 0);
            check("fail cleared", fail8, 0);
            check("err_vec cleared", first_diff(vec8, {N_MAX{1'b0}}), -1);
            model(nn, mm, dd, sg, 8, e); sb8.push_back(e);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb8.size() + sb1.size() + sb32.size()) != 0 && k < 1500) begin
            @(negedge clk);
            k++;
        end
        #1 check("queue drained", sb8.size() + sb1.size() + sb32.size(), 0);
    endtask

    task automatic idle_check();
        repeat (3) @(negedge clk);
        check("idle busy", busy8, 0);
        check("hold err_cnt", cnt8, last8.cnt);
        check("hold fail", fail8, last8.fail);
        check("hold err_vec", first_diff(vec8, last8.vec), -1);
    endtask

    task automatic run(input int nn, input int mm, input int dd, input logic [SW-1:0] sg);
        @(negedge clk);
        drive(nn, mm, dd, sg, 1'b0);
        drain();
        idle_check();
    endtask

    always @(negedge clk) begin
        if (rstn && done8 === 1'b1) begin
            check("p8 busy at done", busy8, 1);
            if (sb8.size() == 0) check("p8 unexpected done", done8, 0);
            else begin last8 = sb8.pop_front(); score("p8", last8, vec8, cnt8, fail8); end
        end
        if (rstn && done1 === 1'b1) begin
            if (sb1.size() == 0) check("p1 unexpected done", done1, 0);
            else begin e1 = sb1.pop_front(); score("p1", e1, vec1, cnt1, fail1); end
        end
        if (rstn && done32 === 1'b1) begin
            if (sb32.size() == 0) check("p32 unexpected done", done32, 0);
            else begin e32 = sb32.pop_front(); score("p32", e32, vec32, cnt32, fail32); end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global timeout: checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [SW-1:0] sg36, sg;
        logic [63:0] rr;
        int a, b, c, mm, dd, nn;

        repeat (3) @(negedge clk);
        check("reset busy", busy8, 0);
        check("reset done", done8, 0);
        check("reset err_cnt", cnt8, 0);
        check("reset fail", fail8, 0);
        check("reset err_vec", first_diff(vec8, {N_MAX{1'b0}}), -1);
        rstn = 1'b1;

        build(6);
        sg36 = pack(1, ap(5), 0, 0, 0);
        run(63, 6, 1, sg36);

        build(10);
        run(1023, 10, 2, pack(1, ap(3) ^ ap(700), ap(703), 0, 0));

        build(8);
        run(100, 8, 2, pack(1, ap(200) ^ ap(7), ap(207), 0, 0));

        run(63, 6, 5, sg36);
        run(63, 7, 1, sg36);
        run(0, 6, 0, pack(1, 0, 0, 0, 0));
        run(0, 6, 2, pack(1, 0, 0, 0, 0));
        run(255, 8, 0, pack(5, 0, 0, 0, 0));

        build(8);
        run(200, 8, 1, pack(1, ap(9), 'h3ff, 'h155, 'h2aa));
        build(6);
        run(63, 6, 1, pack(1 | 'h3c0, ap(40) | 'h380, 0, 0, 0));

        build(10);
        a = ap(0); b = ap(511); c = ap(1022);
        run(1023, 10, 3, pack(1, a ^ b ^ c, gmul(a, b) ^ gmul(a, c) ^ gmul(b, c),
                              gmul(gmul(a, b), c), 0));

        // second start mid-scan must not disturb the running evaluation
        @(negedge clk);
        drive(63, 6, 1, sg36, 1'b0);
        repeat (3) @(negedge clk);
        n = 10'd10; m = 4'd8; degree = 4'd2; sigma = pack(3, 7, 9, 0, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy through ignored start", busy8, 1);
        drain();
        idle_check();

        // reset mid-scan, then start on the first edge after release
        build(10);
        @(negedge clk);
        drive(1023, 10, 2, pack(1, ap(3) ^ ap(700), ap(703), 0, 0), 1'b0);
        repeat (20) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("mid reset busy", busy8, 0);
        check("mid reset done", done8, 0);
        check("mid reset err_cnt", cnt8, 0);
        check("mid reset err_vec", first_diff(vec8, {N_MAX{1'b0}}), -1);
        sb8.delete();
        @(negedge clk);
        rstn = 1'b1;
        drive(63, 6, 1, sg36, 1'b0);
        drain();
        idle_check();

        // block width sweep on the single-error case
        @(negedge clk);
        drive(63, 6, 1, sg36, 1'b1);
        drain();

        for (int r = 0; r < 4; r++) begin
            mm = (r % 3 == 0) ? 6 : ((r % 3 == 1) ? 8 : 10);
            dd = $urandom_range(0, 4);
            nn = $urandom_range(1, 300);
            rr = {$urandom, $urandom};
            sg = rr[SW-1:0];
            run(nn, mm, dd, sg);
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chien_par.md
CHIEN_PAR -- requirements
Module: chien_par

Interface
REQ-001 SHALL have parameter N_MAX, default 1023: maximum codeword length and err_vec width.
REQ-002 SHALL have parameter T_MAX, default 4: maximum locator degree.
REQ-003 SHALL have parameter M_MAX, default 10: maximum field width and sigma coefficient width.
REQ-004 SHALL have parameter P, default 8: positions evaluated per cycle, legal values 1..32.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit: one-cycle request; latches n, m, degree and sigma.
REQ-008 SHALL have port n, input, 10 bits: codeword length, 0..N_MAX.
REQ-009 SHALL have port m, input, 4 bits: field select, legal values 6, 8 and 10.
REQ-010 SHALL have port degree, input, 4 bits: locator degree.
REQ-011 SHALL have port sigma, input, (T_MAX+1)*M_MAX bits: coefficient j at bits [j*M_MAX +: M_MAX]; sigma_0 is the constant term; bits above m are ignored.
REQ-012 SHALL have port busy, output, 1 bit: evaluation in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port err_vec, output, N_MAX bits: bit i set marks error position i.
REQ-015 SHALL have port err_cnt, output, 10 bits: number of roots found.
REQ-016 SHALL have port fail, output, 1 bit: decode failure, valid with done.

Function
REQ-017 SHALL use primitive polynomials per m:
- m=6: x^6+x+1.
- m=8: x^8+x^4+x^3+x^2+1.
- m=10: x^10+x^3+1.
REQ-018 SHALL set err_vec[i]=1, for 0<=i<n, iff Λ(α^-i)=0, where Λ(x)=Σ_{j=0..degree} sigma_j x^j and α^-i=α^(2^m-1-i).
REQ-019 SHALL hold err_vec[i]=0 for all i>=n.
REQ-020 SHALL implement an FSM with states IDLE, EVAL and FIN.
- IDLE -> EVAL on start.
- EVAL evaluates positions kP..kP+P-1 in evaluation cycle k; positions >=n are masked.
- EVAL -> FIN after K=ceil(n/P) evaluation cycles.
- FIN pulses done and returns to IDLE.
REQ-021 SHALL assert done exactly K+1 cycles after the edge that samples start, for a total latency of K+1 cycles.
REQ-022 SHALL keep busy high from the edge after start up to and including the done cycle.
REQ-023 SHALL clear err_vec, err_cnt and fail on the edge that accepts start.
REQ-024 SHALL hold all results stable from done until the next accepted start.
REQ-025 SHALL ignore start while busy=1, with no state change and no effect on results.
REQ-026 SHALL set fail=1 at done iff err_cnt != degree, or degree > T_MAX, or m is illegal.
REQ-027 SHALL skip EVAL when degree > T_MAX or m is illegal: err_vec=0, err_cnt=0, fail=1, done 1 cycle after start.
REQ-028 SHALL skip EVAL when n=0: done 1 cycle after start, err_vec=0, err_cnt=0, fail=(degree!=0).
REQ-029 SHALL, for degree=0, perform a full scan and report err_cnt=0 and fail=0 if sigma_0 != 0.
REQ-030 SHALL treat any coefficient above degree as zero regardless of its input value.
REQ-031 SHALL saturate err_cnt at 1023.
REQ-032 SHALL use only GF(2^m) arithmetic (XOR add, modular multiply), with no per-cycle reload of sigma after latching.

Reset
REQ-033 SHALL, on rstn=0, asynchronously force:
- state=IDLE.
- busy=0 and done=0.
- err_vec=0, err_cnt=0 and fail=0.
- all internal registers to 0.
REQ-034 SHALL, on reset asserted mid-EVAL, abandon the scan without a done pulse.
REQ-035 SHALL accept start on the first rising edge after rstn deasserts.

Verification
REQ-036 SHALL cover single error: m=6, n=63, P=8, degree=1, sigma=(1, α^5) -> done at cycle 9, err_vec bit 5 only, err_cnt=1, fail=0.
REQ-037 SHALL cover double error: m=10, n=1023, P=8, degree=2, Λ=(1+α^3x)(1+α^700x) -> done at cycle 129, bits 3 and 700 set, err_cnt=2, fail=0.
REQ-038 SHALL cover shortened code: m=8, n=100, root at position 200 plus root at position 7, degree=2 -> bit 7 only, err_cnt=1, fail=1.
REQ-039 SHALL cover illegal inputs: degree=5, or m=7 -> done 1 cycle after start, err_vec=0, fail=1; n=0, degree=0 -> done at cycle 1, fail=0.
REQ-040 SHALL cover a second start during EVAL -> ignored, with the original result and timing unchanged.
REQ-041 SHALL cover rstn low mid-EVAL -> outputs zero immediately, no done pulse, and a new start accepted afterwards.
REQ-042 SHALL cover sweeps of P=1 and P=32 for the REQ-036 case -> identical err_vec, with done at cycle 64 and cycle 3 respectively.
